// File: rtl/adder32_seq.sv
// adder32_seq: byte-serial 32-bit add/subtract sequencer.
// One shared 8-bit ripple adder (adder8) is stepped over four cycles, LSB first,
// with the inter-byte carry held in a register.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   req_valid_i  request present           req_ready_o  request can be accepted
//   req_sub_i    0: a+b, 1: a-b            req_a_i/req_b_i  32-bit operands
//   res_valid_o  result available          res_ready_i  consumer takes result
//   res_sum_o    sum/difference mod 2^32   res_carry_o  carry out of bit 31
//   res_ovf_o    signed overflow           res_zero_o   res_sum_o == 0

// adder8: plain 8-bit ripple-carry adder.
//   a_i, b_i  operand bytes   carry_i  carry in
//   sum_o     sum byte        carry_o  carry out of bit 7
module adder8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       carry_i,
  output logic [7:0] sum_o,
  output logic       carry_o
);

  logic c;

  always_comb begin
    sum_o = '0;
    c     = carry_i;
    for (int i = 0; i < 8; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    carry_o = c;
  end

endmodule

module adder32_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_sub_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_sum_o,
  output logic        res_carry_o,
  output logic        res_ovf_o,
  output logic        res_zero_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;      // already inverted for subtraction
  logic [31:0] sum_q;
  logic        carry_q;
  logic        res_carry_q;
  logic        res_ovf_q;
  logic        ready_q;
  logic        valid_q;

  logic [4:0]  byte_base;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [7:0]  add_sum;
  logic        add_carry;

  assign byte_base = {cnt_q, 3'b000};
  assign a_byte    = a_q[byte_base +: 8];
  assign b_byte    = b_q[byte_base +: 8];

  adder8 u_adder8 (
    .a_i     (a_byte),
    .b_i     (b_byte),
    .carry_i (carry_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            a_q         <= req_a_i;
            b_q         <= req_sub_i ? ~req_b_i : req_b_i;
            carry_q     <= req_sub_i;  // the +1 of two's-complement negation
            cnt_q       <= 2'd0;
            sum_q       <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            ready_q     <= 1'b0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          sum_q[byte_base +: 8] <= add_sum;
          carry_q               <= add_carry;
          cnt_q                 <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            res_carry_q <= add_carry;
            // Carry into bit 31 is recovered as a ^ b ^ sum at that bit.
            res_ovf_q   <= add_carry ^ (a_q[31] ^ b_q[31] ^ add_sum[7]);
            valid_q     <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign res_valid_o = valid_q;
  assign res_sum_o   = sum_q;
  assign res_carry_o = res_carry_q;
  assign res_ovf_o   = res_ovf_q;
  assign res_zero_o  = (sum_q == 32'd0);

endmodule

// File: tb/tb_adder32_seq.sv
// Self-checking bench for adder32_seq: directed vectors, randomized operations
// against an arithmetic reference model, backpressure, mid-operation reset and
// minimum accept spacing.
module tb_adder32_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_sub;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_carry;
  logic        res_ovf;
  logic        res_zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  adder32_seq dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_sub_i   (req_sub),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .res_carry_o (res_carry),
    .res_ovf_o   (res_ovf),
    .res_zero_o  (res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Reference: 33-bit arithmetic; overflow from operand/result signs.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                    output logic [31:0] sum, output logic carry,
                                    output logic ovf);
    logic [32:0] full;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else     full = {1'b0, a} + {1'b0, b};
    sum   = full[31:0];
    carry = full[32];
    if (sub) ovf = (a[31] != b[31]) && (sum[31] != a[31]);
    else     ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  endfunction

  // Drives one request (DUT assumed idle); returns #1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output int acc_cyc);
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  // Number of edges after accept until res_valid is seen (-1 on timeout).
  task automatic wait_result(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sub   = 1'b0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({req_ready, res_valid, res_sum, res_carry, res_ovf, res_zero} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%h c=%b o=%b z=%b, need rdy=1 vld=0 sum=0 c=0 o=0 z=1",
               req_ready, res_valid, res_sum, res_carry, res_ovf, res_zero);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    int   acc;
    int   n;
    v[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    v[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    v[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    v[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    v[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    v[5] = '{32'h00000009, 32'h00000009, 1'b1, 32'h00000000, 1'b1, 1'b0};
    v[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
    v[7] = '{32'hFFFFFF00, 32'h00000100, 1'b0, 32'h00000000, 1'b1, 1'b0};
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(v[i].a, v[i].b, v[i].sub, acc);
      wait_result(n);
      tests++;
      if (n !== 4) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got %0d edges, need 4", i, n);
      end
      tests++;
      if ({res_sum, res_carry, res_ovf, res_zero} !==
          {v[i].sum, v[i].carry, v[i].ovf, (v[i].sum == 32'd0)}) begin
        fails++;
        $display("FAIL directed_result[%0d]: sum=%h c=%b o=%b z=%b, need sum=%h c=%b o=%b z=%b",
                 i, res_sum, res_carry, res_ovf, res_zero, v[i].sum, v[i].carry, v[i].ovf,
                 (v[i].sum == 32'd0));
      end
      @(posedge clk);
      #1;
      tests++;
      if ({req_ready, res_valid} !== 2'b10) begin
        fails++;
        $display("FAIL directed_consume[%0d]: rdy=%b vld=%b, need rdy=1 vld=0", i, req_ready, res_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, esum;
    logic        sub, ec, eo;
    int          acc, n, hold;
    for (int i = 0; i < 40; i++) begin
      a    = $urandom;
      b    = $urandom;
      sub  = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      if (i % 8 == 0) b = a;  // exercise the zero flag
      ref_model(a, b, sub, esum, ec, eo);
      res_ready = (hold == 0);
      issue(a, b, sub, acc);
      wait_result(n);
      tests++;
      if (n !== 4 || {res_sum, res_carry, res_ovf, res_zero} !== {esum, ec, eo, (esum == 32'd0)}) begin
        fails++;
        $display("FAIL random[%0d] %h %s %h: lat=%0d sum=%h c=%b o=%b z=%b, need lat=4 sum=%h c=%b o=%b z=%b",
                 i, a, sub ? "-" : "+", b, n, res_sum, res_carry, res_ovf, res_zero,
                 esum, ec, eo, (esum == 32'd0));
      end
      repeat (hold) @(posedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({req_ready, res_valid} !== 2'b10) begin
        fails++;
        $display("FAIL random_consume[%0d]: rdy=%b vld=%b, need rdy=1 vld=0", i, req_ready, res_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, n;
    res_ready = 1'b0;
    issue(32'h12345678, 32'h11111111, 1'b0, acc);
    // Requests offered while busy must be ignored.
    for (int i = 0; i < 3; i++) begin
      req_a     = $urandom;
      req_b     = $urandom;
      req_sub   = 1'($urandom_range(0, 1));
      req_valid = ~req_valid;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    n = res_valid ? 4 : -1;
    tests++;
    if (n !== 4 || {res_sum, res_carry, res_ovf} !== {32'h23456789, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL bp_first: vld=%b sum=%h c=%b o=%b, need vld=1 sum=23456789 c=0 o=0",
               res_valid, res_sum, res_carry, res_ovf);
    end
    for (int i = 0; i < 10; i++) begin
      req_a     = $urandom;
      req_b     = $urandom;
      req_valid = ~req_valid;
      @(posedge clk);
      #1;
      tests++;
      if ({req_ready, res_valid, res_sum, res_carry, res_ovf, res_zero} !==
          {1'b0, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b sum=%h c=%b o=%b z=%b, need rdy=0 vld=1 sum=23456789 c=0 o=0 z=0",
                 i, req_ready, res_valid, res_sum, res_carry, res_ovf, res_zero);
      end
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({req_ready, res_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_release: rdy=%b vld=%b, need rdy=1 vld=0", req_ready, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    int acc, n;
    res_ready = 1'b1;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, acc);
    repeat (2) @(posedge clk);  // byte counter now at 2
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests++;
    if ({req_ready, res_valid, res_sum, res_carry, res_ovf, res_zero} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL midreset_state: rdy=%b vld=%b sum=%h c=%b o=%b z=%b, need rdy=1 vld=0 sum=0 c=0 o=0 z=1",
               req_ready, res_valid, res_sum, res_carry, res_ovf, res_zero);
    end
    issue(32'h1, 32'h2, 1'b0, acc);
    wait_result(n);
    tests++;
    if (n !== 4 || {res_sum, res_carry, res_ovf, res_zero} !== {32'h3, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midreset_next: lat=%0d sum=%h c=%b o=%b z=%b, need lat=4 sum=00000003 c=0 o=0 z=0",
               n, res_sum, res_carry, res_ovf, res_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, esum;
    logic        ec, eo;
    int          acc, prev, n;
    res_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      ref_model(a, b, 1'b0, esum, ec, eo);
      issue(a, b, 1'b0, acc);
      if (prev >= 0) begin
        tests++;
        if (acc - prev !== 6) begin
          fails++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, need 6", i, acc - prev);
        end
      end
      prev = acc;
      wait_result(n);
      tests++;
      if (n !== 4 || {res_sum, res_carry, res_ovf} !== {esum, ec, eo}) begin
        fails++;
        $display("FAIL b2b_result[%0d]: lat=%0d sum=%h c=%b o=%b, need lat=4 sum=%h c=%b o=%b",
                 i, n, res_sum, res_carry, res_ovf, esum, ec, eo);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder32_seq.md
# adder32_seq

Byte-serial 32-bit add/subtract sequencer built around a single 8-bit ripple adder (`adder8`). It accepts one operation per request handshake and latches the operands. It then drives the shared `adder8` over four consecutive cycles, least-significant byte first, chaining the carry through a register. The assembled 32-bit result and flags are returned on a result handshake. It serves as the area-reduced arithmetic path for the CPU's multi-cycle execute option.

## Interface

Parameters: none. Operand width is fixed at 32 bits, processed as 4 bytes.

Ports:
- clk_i  in  1  — sole clock; all state changes on the rising edge.
- rst_ni  in  1  — reset, synchronous, active-low.
- req_valid_i  in  1  — request present.
- req_ready_o  out  1  — sequencer can accept a request.
- req_sub_i  in  1  — 0: a+b; 1: a−b, computed as a + ~b + 1.
- req_a_i  in  32  — operand A.
- req_b_i  in  32  — operand B.
- res_valid_o  out  1  — result available.
- res_ready_i  in  1  — consumer takes the result.
- res_sum_o  out  32  — 32-bit sum/difference, mod 2^32.
- res_carry_o  out  1  — carry out of bit 31. For subtraction, 1 = no borrow.
- res_ovf_o  out  1  — signed overflow.
- res_zero_o  out  1  — res_sum_o == 0.

## Operation

- Exactly one `adder8` instance. Its inputs are a byte of the latched A, a byte of the latched B (inverted if sub), and the carry register.
- FSM states:
  - IDLE: req_ready_o=1.
  - BUSY: 2-bit byte counter cnt, 0..3.
  - DONE: res_valid_o=1.
- IDLE → BUSY on req_valid_i & req_ready_o. On that edge:
  - A is latched.
  - B is latched as b_eff = req_sub_i ? ~req_b_i : req_b_i.
  - carry_q <= req_sub_i.
  - cnt <= 0.
  - The result register is cleared.
- BUSY, each edge:
  - res_sum[8*cnt+7 : 8*cnt] <= adder8.sum.
  - carry_q <= adder8.carry_out.
  - cnt <= cnt+1.
  - When cnt==3, the next state is DONE.
- BUSY, cnt==3 edge, additionally:
  - res_carry <= carry_out.
  - res_ovf <= carry_out ^ (a[31] ^ b_eff[31] ^ sum_byte[7]). This is the carry-out xor the carry-in of bit 31.
- DONE → IDLE on res_ready_i. Result outputs hold stable while res_valid_o=1 and res_ready_i=0.
- req_valid_i is ignored outside IDLE, since req_ready_o=0 there. No request is accepted in the same cycle a result is consumed.
- res_zero_o is derived combinationally from res_sum_o and is meaningful only while res_valid_o=1.
- Reset, at any time including mid-BUSY: state IDLE, cnt 0, carry_q 0, result/flag registers 0. Any in-flight operation is discarded with no result produced.

## Timing

- Reset values:
  - req_ready_o=1, res_valid_o=0.
  - res_sum_o=0, res_carry_o=0, res_ovf_o=0.
  - res_zero_o=1, since the sum is 0.
- Latency: the request is accepted at edge E0. Bytes 0..3 are written at E1..E4. res_valid_o rises after E4, i.e. 4 cycles after acceptance.
- Minimum spacing between accepts is 6 cycles: E0 accept, E1–E4 compute, E5 consume (res_ready_i already high), E6 next accept.
- All outputs are registered except res_zero_o, which is combinational from a register. There is no combinational path from req_* or res_ready_i to any output other than through the FSM state.
- Critical path: one 8-bit ripple plus the register setup.

## Test plan

- Reset, then add 0xFFFFFFFF + 0x00000001, res_ready_i=1 -> res_valid_o high exactly 4 cycles after accept; sum=0x00000000, carry=1, ovf=0, zero=1; req_ready_o back to 1 one cycle later.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, carry=0, ovf=1, zero=0. Add 0x12345678 + 0x11111111 -> sum=0x23456789, carry=0, ovf=0.
- Sub 5 − 7 -> sum=0xFFFFFFFE, carry=0 (borrow), ovf=0. Sub 0x80000000 − 1 -> sum=0x7FFFFFFF, carry=1, ovf=1. Sub 9 − 9 -> sum=0, zero=1, carry=1.
- Backpressure: hold res_ready_i=0 for 10 cycles after res_valid_o rises -> outputs stable and req_ready_o=0 throughout. Toggle req_valid_i with new operands during BUSY and DONE -> no accept; the first result is unchanged.
- Reset mid-op: assert rst_ni=0 for one edge while cnt==2 -> after the edge, IDLE with all outputs at reset values. A new request 0x1 + 0x2 then completes with sum=0x3 and no residue from the aborted operation.
- Carry chaining across bytes: 0x00FF00FF + 0x00010001 -> sum=0x01000100, carry=0. 0xFFFFFF00 + 0x00000100 -> sum=0x00000000, carry=1.
